// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the decode-stage jr hazard logic of
//                the 5-stage MIPS datapath: instruction-field constants, the
//                per-stage destination-tracking record and its bubble value.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Register-specifier width carried in the tracking records.
    localparam int PIPE_REG_W = 5;

    localparam logic [5:0]            OP_RTYPE = 6'b000000;
    localparam logic [5:0]            FUNCT_JR = 6'b001000;
    localparam logic [PIPE_REG_W-1:0] REG_ZERO = '0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                  valid;
        logic [PIPE_REG_W-1:0] dest;
        logic                  regWrite;
        logic                  memRead;
    } stage_rec_t;

    // An empty slot: no instruction, no write, no load.
    localparam stage_rec_t BUBBLE = '0;

    // True for "jr rs" (R-type, funct jr). $0 filtering is done by the caller.
    function automatic logic is_jr(input logic [5:0] opcode,
                                   input logic [5:0] funct);
        return (opcode == OP_RTYPE) && (funct == FUNCT_JR);
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/dest_track_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dest_track_stage
//  Description : One pipeline-stage destination record. Loads rec_in every
//                rising edge, or a bubble when load_bubble is set. Cleared
//                to a bubble asynchronously while rst_n is low.
//  Ports       : clk          in   pipeline clock
//                rst_n        in   asynchronous active-low clear
//                load_bubble  in   load BUBBLE instead of rec_in
//                rec_in       in   record entering this stage
//                rec_out      out  record currently held in this stage
//  Revision    : 1.0 - initial release
// ============================================================================
module dest_track_stage
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_bubble,
    input  stage_rec_t rec_in,
    output stage_rec_t rec_out
);

    stage_rec_t rec_d;
    stage_rec_t rec_q;

    always_comb begin
        rec_d = rec_in;
        if (load_bubble) begin
            rec_d = BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q <= BUBBLE;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec_out = rec_q;

endmodule : dest_track_stage
`default_nettype wire

// File: rtl/jr_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : jr_hazard_unit
//  Description : Producer-side companion to the decode-stage jr forwarding
//                mux. Tracks in-flight register writes through EX and MEM,
//                stalls decode while a jr's rs is not yet forwardable, and
//                selects the MEM ALU result as the jr target when it is.
//
//  Optional    : JR_STALL_CNT_EN - when defined, adds parameter CNT_W and
//                output jr_stalls, a saturating count of stalled cycles.
//
//  Ports       : clk        in   pipeline clock
//                rst_n      in   asynchronous active-low reset
//                opcodeD    in   opcode of the decode instruction
//                functD     in   funct field of the decode instruction
//                rsD        in   rs of the decode instruction
//                destD      in   destination of the decode instruction
//                regWriteD  in   decode instruction writes a register
//                memReadD   in   decode instruction is a load
//                flushD     in   squash decode instruction (EX gets bubble)
//                stallD     out  hold PC and IF/ID, bubble into EX
//                fwdD_sel   out  1 = jr target from MEM ALU result
//                rdM        out  MEM-stage destination (0 when empty)
//                regWriteM  out  MEM-stage write enable (0 when empty)
//                jr_stalls  out  stall-cycle count (JR_STALL_CNT_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module jr_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = PIPE_REG_W
`ifdef JR_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcodeD,
    input  logic [5:0]       functD,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] destD,
    input  logic             regWriteD,
    input  logic             memReadD,
    input  logic             flushD,
    output logic             stallD,
    output logic             fwdD_sel,
    output logic [REG_W-1:0] rdM,
    output logic             regWriteM
`ifdef JR_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] jr_stalls
`endif
);

    stage_rec_t e_rec;
    stage_rec_t m_rec;
    stage_rec_t e_in;
    logic       e_bubble;

    logic jrD;
    logic hitE;
    logic hitM;

    // ------------------------------------------------------------------
    // Destination tracker: decode -> E -> M
    // ------------------------------------------------------------------
    // A stalled decode instruction stays in IF/ID, so only a bubble may
    // advance into E; a flushed one is dropped the same way.
    assign e_bubble = stallD || flushD;

    always_comb begin
        e_in          = BUBBLE;
        e_in.valid    = 1'b1;
        e_in.dest     = destD;
        e_in.regWrite = regWriteD;
        e_in.memRead  = memReadD;
    end

    dest_track_stage u_stage_e (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_bubble (e_bubble),
        .rec_in      (e_in),
        .rec_out     (e_rec)
    );

    dest_track_stage u_stage_m (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_bubble (1'b0),
        .rec_in      (e_rec),
        .rec_out     (m_rec)
    );

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // $0 is hard-wired, so a jr through it never waits on a producer.
    assign jrD  = is_jr(opcodeD, functD) && (rsD != REG_ZERO);

    assign hitE = jrD && e_rec.valid && e_rec.regWrite && (e_rec.dest == rsD);
    assign hitM = jrD && m_rec.valid && m_rec.regWrite && (m_rec.dest == rsD);

    always_comb begin
        stallD   = 1'b0;
        fwdD_sel = 1'b0;
        // Anything in E is not yet produced; a load in M still has its data
        // in the memory stage. Both wait. Once the load reaches WB the
        // write-first register file supplies the value directly.
        if (hitE || (hitM && m_rec.memRead)) begin
            stallD = 1'b1;
        end
        // The E writer is younger, so when both match it owns the value and
        // the M result must not be forwarded.
        if (hitM && !m_rec.memRead && !hitE) begin
            fwdD_sel = 1'b1;
        end
    end

    // Empty slots report no destination and no write.
    assign rdM       = m_rec.valid ? m_rec.dest : '0;
    assign regWriteM = m_rec.valid && m_rec.regWrite;

`ifdef JR_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] jr_stalls_d;
    logic [CNT_W-1:0] jr_stalls_q;

    always_comb begin
        jr_stalls_d = jr_stalls_q;
        if (stallD && (jr_stalls_q != {CNT_W{1'b1}})) begin
            jr_stalls_d = jr_stalls_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jr_stalls_q <= '0;
        end else begin
            jr_stalls_q <= jr_stalls_d;
        end
    end

    assign jr_stalls = jr_stalls_q;
`endif

endmodule : jr_hazard_unit
`default_nettype wire
